// File: rtl/ddr3_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_cmd_arbiter
// Purpose  : Shares the DDL command port between the cfg/refresh sequencer
//            (highest priority), the main controller FSM (port A) and the
//            fast-read bypass controller (port B). Registered grant,
//            round-robin between A and B, sequence locking for atomic
//            ACT->RD/WR->PRE transactions.
// Revision : 1.0  initial release
// ============================================================================
module ddr3_cmd_arbiter #(
   parameter int              DDR_ROW_BITS = 15,
   parameter logic [2:0]      CMD_NOP      = 3'b111,
   parameter int              MAX_SEQ      = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cfg_run_i,
   input  logic                    ref_i,
   input  logic                    cfg_req_i,
   input  logic                    cfg_seq_i,
   input  logic [2:0]              cfg_cmd_i,
   input  logic [2:0]              cfg_ba_i,
   input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
   output logic                    cfg_rdy_o,
   input  logic                    a_req_i,
   input  logic                    a_seq_i,
   input  logic [2:0]              a_cmd_i,
   input  logic [2:0]              a_ba_i,
   input  logic [DDR_ROW_BITS-1:0] a_adr_i,
   output logic                    a_rdy_o,
   output logic                    a_ref_o,
   input  logic                    b_req_i,
   input  logic                    b_seq_i,
   input  logic [2:0]              b_cmd_i,
   input  logic [2:0]              b_ba_i,
   input  logic [DDR_ROW_BITS-1:0] b_adr_i,
   output logic                    b_rdy_o,
   output logic                    b_ref_o,
   output logic                    ddl_req_o,
   output logic                    ddl_seq_o,
   output logic [2:0]              ddl_cmd_o,
   output logic [2:0]              ddl_ba_o,
   output logic [DDR_ROW_BITS-1:0] ddl_adr_o,
   input  logic                    ddl_rdy_i,
   output logic                    lock_err_o
);

   // Last count value allowed under one lock; the accept at this count forces release.
   localparam logic [7:0] SEQ_LAST = 8'(MAX_SEQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      G_CFG = 2'd1,
      G_A   = 2'd2,
      G_B   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic       rr_q, rr_d;          // 0: A preferred, 1: B preferred
   logic [7:0] count_q, count_d;
   logic       lock_err_q, lock_err_d;

   logic       sel_req;
   logic       sel_seq;

   // Refresh pending is simply forwarded to both controllers.
   assign a_ref_o    = ref_i;
   assign b_ref_o    = ref_i;
   assign lock_err_o = lock_err_q;

   // Command mux: the granted port drives the DDL; IDLE drives a NOP.
   always_comb begin
      ddl_req_o = 1'b0;
      ddl_seq_o = 1'b0;
      ddl_cmd_o = CMD_NOP;
      ddl_ba_o  = 3'd0;
      ddl_adr_o = '0;
      cfg_rdy_o = 1'b0;
      a_rdy_o   = 1'b0;
      b_rdy_o   = 1'b0;
      sel_req   = 1'b0;
      sel_seq   = 1'b0;
      case (state_q)
         G_CFG: begin
            ddl_req_o = cfg_req_i;
            ddl_seq_o = cfg_seq_i;
            ddl_cmd_o = cfg_cmd_i;
            ddl_ba_o  = cfg_ba_i;
            ddl_adr_o = cfg_adr_i;
            cfg_rdy_o = ddl_rdy_i & cfg_req_i;
            sel_req   = cfg_req_i;
            sel_seq   = cfg_seq_i;
         end
         G_A: begin
            ddl_req_o = a_req_i;
            ddl_seq_o = a_seq_i;
            ddl_cmd_o = a_cmd_i;
            ddl_ba_o  = a_ba_i;
            ddl_adr_o = a_adr_i;
            a_rdy_o   = ddl_rdy_i & a_req_i;
            sel_req   = a_req_i;
            sel_seq   = a_seq_i;
         end
         G_B: begin
            ddl_req_o = b_req_i;
            ddl_seq_o = b_seq_i;
            ddl_cmd_o = b_cmd_i;
            ddl_ba_o  = b_ba_i;
            ddl_adr_o = b_adr_i;
            b_rdy_o   = ddl_rdy_i & b_req_i;
            sel_req   = b_req_i;
            sel_seq   = b_seq_i;
         end
         default: ;
      endcase
   end

   // Grant selection, lock tracking and forced release.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      count_d    = count_q;
      lock_err_d = lock_err_q;
      if (state_q == IDLE) begin
         count_d = 8'd0;
         if (cfg_req_i) begin
            state_d = G_CFG;
         end else if (cfg_run_i && !ref_i) begin
            if (a_req_i && b_req_i) begin
               state_d = rr_q ? G_B : G_A;
            end else if (a_req_i) begin
               state_d = G_A;
            end else if (b_req_i) begin
               state_d = G_B;
            end
         end
      end else if (!sel_req) begin
         // Requester dropped its request while granted: abandon the grant.
         state_d = IDLE;
         count_d = 8'd0;
      end else if (ddl_rdy_i) begin
         if (!sel_seq || (count_q == SEQ_LAST)) begin
            state_d = IDLE;
            count_d = 8'd0;
            if (sel_seq) begin
               lock_err_d = 1'b1;
            end
            // Hand preference to the other A/B port after a completed grant.
            if (state_q == G_A) begin
               rr_d = 1'b1;
            end else if (state_q == G_B) begin
               rr_d = 1'b0;
            end
         end else begin
            count_d = count_q + 8'd1;
         end
      end
   end

   // State registers with asynchronous reset so a mid-lock reset releases the port at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         count_q    <= 8'd0;
         lock_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         count_q    <= count_d;
         lock_err_q <= lock_err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_cmd_arbiter
// Purpose  : Self-checking bench for ddr3_cmd_arbiter: directed scenarios
//            plus a randomized run against a cycle-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr3_cmd_arbiter;

   localparam int         RB      = 15;
   localparam int         MAXS    = 8;
   localparam logic [2:0] NOP     = 3'b111;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cfg_run_i, ref_i;
   logic          cfg_req_i, cfg_seq_i, a_req_i, a_seq_i, b_req_i, b_seq_i;
   logic [2:0]    cfg_cmd_i, cfg_ba_i, a_cmd_i, a_ba_i, b_cmd_i, b_ba_i;
   logic [RB-1:0] cfg_adr_i, a_adr_i, b_adr_i;
   logic          cfg_rdy_o, a_rdy_o, b_rdy_o, a_ref_o, b_ref_o;
   logic          ddl_req_o, ddl_seq_o, ddl_rdy_i, lock_err_o;
   logic [2:0]    ddl_cmd_o, ddl_ba_o;
   logic [RB-1:0] ddl_adr_o;

   int vectors = 0;
   int errors  = 0;

   ddr3_cmd_arbiter #(.DDR_ROW_BITS(RB), .CMD_NOP(NOP), .MAX_SEQ(MAXS)) dut (
      .clock(clock), .reset(reset), .cfg_run_i(cfg_run_i), .ref_i(ref_i),
      .cfg_req_i(cfg_req_i), .cfg_seq_i(cfg_seq_i), .cfg_cmd_i(cfg_cmd_i),
      .cfg_ba_i(cfg_ba_i), .cfg_adr_i(cfg_adr_i), .cfg_rdy_o(cfg_rdy_o),
      .a_req_i(a_req_i), .a_seq_i(a_seq_i), .a_cmd_i(a_cmd_i), .a_ba_i(a_ba_i),
      .a_adr_i(a_adr_i), .a_rdy_o(a_rdy_o), .a_ref_o(a_ref_o),
      .b_req_i(b_req_i), .b_seq_i(b_seq_i), .b_cmd_i(b_cmd_i), .b_ba_i(b_ba_i),
      .b_adr_i(b_adr_i), .b_rdy_o(b_rdy_o), .b_ref_o(b_ref_o),
      .ddl_req_o(ddl_req_o), .ddl_seq_o(ddl_seq_o), .ddl_cmd_o(ddl_cmd_o),
      .ddl_ba_o(ddl_ba_o), .ddl_adr_o(ddl_adr_o), .ddl_rdy_i(ddl_rdy_i),
      .lock_err_o(lock_err_o)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic quiet_inputs();
      cfg_run_i = 1'b1; ref_i = 1'b0; ddl_rdy_i = 1'b0;
      cfg_req_i = 1'b0; cfg_seq_i = 1'b0; cfg_cmd_i = 3'd0; cfg_ba_i = 3'd0; cfg_adr_i = '0;
      a_req_i   = 1'b0; a_seq_i   = 1'b0; a_cmd_i   = 3'd0; a_ba_i   = 3'd0; a_adr_i   = '0;
      b_req_i   = 1'b0; b_seq_i   = 1'b0; b_cmd_i   = 3'd0; b_ba_i   = 3'd0; b_adr_i   = '0;
   endtask

   task automatic do_reset();
      quiet_inputs();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   // Outputs right after reset: NOP, no rdy, no error.
   task automatic test_reset();
      do_reset();
      @(negedge clock);
      vectors++;
      if ({ddl_req_o, ddl_seq_o, ddl_cmd_o, ddl_ba_o, cfg_rdy_o, a_rdy_o, b_rdy_o, lock_err_o}
          !== {1'b0, 1'b0, NOP, 3'd0, 4'd0} || ddl_adr_o !== '0) begin
         errors++;
         $display("FAIL reset: req=%b cmd=%b ba=%b adr=%h rdy=%b%b%b err=%b, required req=0 cmd=111 rest 0",
                  ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o, cfg_rdy_o, a_rdy_o, b_rdy_o, lock_err_o);
      end
      cyc();
   endtask

   // Before init completes only cfg may use the port.
   task automatic test_cfg_only();
      do_reset();
      cfg_run_i = 1'b0; a_req_i = 1'b1; a_cmd_i = 3'b011;
      cfg_req_i = 1'b1; cfg_cmd_i = 3'b010; cfg_ba_i = 3'd5; cfg_adr_i = 15'h1234;
      cyc();
      @(negedge clock);
      vectors++;
      if (ddl_req_o !== 1'b1 || ddl_cmd_o !== 3'b010 || ddl_ba_o !== 3'd5 || ddl_adr_o !== 15'h1234) begin
         errors++;
         $display("FAIL cfg_grant: req=%b cmd=%b ba=%0d adr=%h, required 1 010 5 1234",
                  ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o);
      end
      ddl_rdy_i = 1'b1;
      #1;
      vectors++;
      if (cfg_rdy_o !== 1'b1 || a_rdy_o !== 1'b0) begin
         errors++;
         $display("FAIL cfg_rdy: cfg_rdy=%b a_rdy=%b, required 1 0", cfg_rdy_o, a_rdy_o);
      end
      cyc();
      cfg_req_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         vectors++;
         if (ddl_req_o !== 1'b0 || a_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL cfg_only_no_a[%0d]: req=%b a_rdy=%b, required 0 0", i, ddl_req_o, a_rdy_o);
         end
         cyc();
      end
   endtask

   // A and B alternate with an IDLE cycle between grants.
   task automatic test_round_robin();
      int own [6] = '{0, 1, 0, 2, 0, 1};
      logic [2:0] ecmd;
      do_reset();
      a_req_i = 1'b1; a_cmd_i = 3'b001; b_req_i = 1'b1; b_cmd_i = 3'b010; ddl_rdy_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         ecmd = (own[i] == 1) ? 3'b001 : (own[i] == 2) ? 3'b010 : NOP;
         vectors++;
         if (ddl_req_o !== (own[i] != 0) || a_rdy_o !== (own[i] == 1) ||
             b_rdy_o !== (own[i] == 2) || ddl_cmd_o !== ecmd) begin
            errors++;
            $display("FAIL round_robin[%0d]: req=%b a_rdy=%b b_rdy=%b cmd=%b, required owner %0d cmd=%b",
                     i, ddl_req_o, a_rdy_o, b_rdy_o, ddl_cmd_o, own[i], ecmd);
         end
         cyc();
      end
   endtask

   // ACT/RD/PRE under one lock stays contiguous; B follows after IDLE.
   task automatic test_seq_lock();
      int own [6] = '{0, 1, 1, 1, 0, 2};
      logic [2:0] ecmd [6] = '{NOP, 3'b011, 3'b101, 3'b010, NOP, 3'b100};
      do_reset();
      b_req_i = 1'b1; b_cmd_i = 3'b100; ddl_rdy_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a_req_i = (i <= 3);
         a_seq_i = (i <= 2);
         a_cmd_i = (i <= 1) ? 3'b011 : (i == 2) ? 3'b101 : 3'b010;
         @(negedge clock);
         vectors++;
         if (ddl_req_o !== (own[i] != 0) || a_rdy_o !== (own[i] == 1) ||
             b_rdy_o !== (own[i] == 2) || ddl_cmd_o !== ecmd[i]) begin
            errors++;
            $display("FAIL seq_lock[%0d]: req=%b a_rdy=%b b_rdy=%b cmd=%b, required owner %0d cmd=%b",
                     i, ddl_req_o, a_rdy_o, b_rdy_o, ddl_cmd_o, own[i], ecmd[i]);
         end
         cyc();
      end
   endtask

   // Refresh lets a held lock finish, blocks B, but not cfg. Owner 3 = cfg.
   task automatic test_refresh();
      int own [10] = '{0, 1, 1, 1, 0, 0, 0, 2, 0, 3};
      do_reset();
      ddl_rdy_i = 1'b1; b_cmd_i = 3'b100; cfg_cmd_i = 3'b001;
      for (int i = 0; i < 10; i++) begin
         ref_i     = ((i >= 1) && (i <= 5)) || (i >= 8);
         a_req_i   = (i <= 3);
         a_seq_i   = (i <= 2);
         b_req_i   = (i <= 7);
         cfg_req_i = (i >= 8);
         @(negedge clock);
         vectors++;
         if (ddl_req_o !== (own[i] != 0) || a_rdy_o !== (own[i] == 1) || b_rdy_o !== (own[i] == 2) ||
             cfg_rdy_o !== (own[i] == 3) || a_ref_o !== ref_i || b_ref_o !== ref_i) begin
            errors++;
            $display("FAIL refresh[%0d]: req=%b rdy cfg/a/b=%b%b%b ref a/b=%b%b, required owner %0d ref=%b",
                     i, ddl_req_o, cfg_rdy_o, a_rdy_o, b_rdy_o, a_ref_o, b_ref_o, own[i], ref_i);
         end
         cyc();
      end
   endtask

   // Eight locked accepts force a release and set the sticky error.
   task automatic test_max_seq();
      do_reset();
      a_req_i = 1'b1; a_seq_i = 1'b1; ddl_rdy_i = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clock);
         vectors++;
         if (ddl_req_o !== ((i >= 1 && i <= MAXS) || i == MAXS + 2) || lock_err_o !== (i >= MAXS + 1)) begin
            errors++;
            $display("FAIL max_seq[%0d]: req=%b err=%b, required req=%b err=%b", i, ddl_req_o, lock_err_o,
                     ((i >= 1 && i <= MAXS) || i == MAXS + 2), (i >= MAXS + 1));
         end
         cyc();
      end
      do_reset();
      @(negedge clock);
      vectors++;
      if (lock_err_o !== 1'b0) begin
         errors++;
         $display("FAIL lock_err_clear: err=%b, required 0", lock_err_o);
      end
      cyc();
   endtask

   // Reset releases a stalled B grant without waiting for a clock edge.
   task automatic test_async_reset();
      do_reset();
      b_req_i = 1'b1; b_cmd_i = 3'b100;
      cyc();
      @(negedge clock);
      vectors++;
      if (ddl_req_o !== 1'b1 || ddl_cmd_o !== 3'b100) begin
         errors++;
         $display("FAIL async_pre: req=%b cmd=%b, required 1 100", ddl_req_o, ddl_cmd_o);
      end
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (ddl_req_o !== 1'b0 || ddl_cmd_o !== NOP || b_rdy_o !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: req=%b cmd=%b b_rdy=%b, required 0 111 0", ddl_req_o, ddl_cmd_o, b_rdy_o);
      end
      cyc();
      reset = 1'b0;
      quiet_inputs();
   endtask

   // Random traffic against a cycle-level model of the arbitration rules.
   task automatic test_random();
      int   owner = 0;      // 0 none, 1 cfg, 2 A, 3 B
      bit   pref_b = 0;
      int   run_len = 0;    // locked accepts so far in this grant
      bit   err = 0;
      logic m_req, m_seq;
      logic [2:0] m_cmd, m_ba;
      logic [RB-1:0] m_adr;
      logic [28:0] exp_v, act_v;
      do_reset();
      for (int n = 0; n < 500; n++) begin
         cfg_run_i = ($urandom_range(0, 9) != 0);
         ref_i     = ($urandom_range(0, 4) == 0);
         ddl_rdy_i = ($urandom_range(0, 9) < 7);
         cfg_req_i = ($urandom_range(0, 9) == 0);
         a_req_i   = ($urandom_range(0, 9) < 6);
         b_req_i   = ($urandom_range(0, 9) < 6);
         cfg_seq_i = $urandom_range(0, 1); a_seq_i = ($urandom_range(0, 9) < 7); b_seq_i = $urandom_range(0, 1);
         cfg_cmd_i = 3'($urandom); a_cmd_i = 3'($urandom); b_cmd_i = 3'($urandom);
         cfg_ba_i  = 3'($urandom); a_ba_i  = 3'($urandom); b_ba_i  = 3'($urandom);
         cfg_adr_i = RB'($urandom); a_adr_i = RB'($urandom); b_adr_i = RB'($urandom);
         @(negedge clock);
         {m_req, m_seq, m_cmd, m_ba, m_adr} = {1'b0, 1'b0, NOP, 3'd0, {RB{1'b0}}};
         if (owner == 1) {m_req, m_seq, m_cmd, m_ba, m_adr} = {cfg_req_i, cfg_seq_i, cfg_cmd_i, cfg_ba_i, cfg_adr_i};
         if (owner == 2) {m_req, m_seq, m_cmd, m_ba, m_adr} = {a_req_i, a_seq_i, a_cmd_i, a_ba_i, a_adr_i};
         if (owner == 3) {m_req, m_seq, m_cmd, m_ba, m_adr} = {b_req_i, b_seq_i, b_cmd_i, b_ba_i, b_adr_i};
         exp_v = {m_req, m_seq, m_cmd, m_ba, m_adr,
                  (owner == 1) && m_req && ddl_rdy_i, (owner == 2) && m_req && ddl_rdy_i,
                  (owner == 3) && m_req && ddl_rdy_i, ref_i, ref_i, err};
         act_v = {ddl_req_o, ddl_seq_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o,
                  cfg_rdy_o, a_rdy_o, b_rdy_o, a_ref_o, b_ref_o, lock_err_o};
         vectors++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL random[%0d]: outputs=%h, required %h (owner %0d)", n, act_v, exp_v, owner);
         end
         // Advance the model by one clock.
         if (owner == 0) begin
            run_len = 0;
            if (cfg_req_i) owner = 1;
            else if (cfg_run_i && !ref_i) begin
               if (a_req_i && b_req_i) owner = pref_b ? 3 : 2;
               else if (a_req_i)       owner = 2;
               else if (b_req_i)       owner = 3;
            end
         end else if (!m_req) begin
            owner = 0; run_len = 0;
         end else if (ddl_rdy_i) begin
            run_len++;
            if (!m_seq || run_len >= MAXS) begin
               if (m_seq) err = 1;
               if (owner == 2) pref_b = 1;
               if (owner == 3) pref_b = 0;
               owner = 0; run_len = 0;
            end
         end
         cyc();
      end
   endtask

   initial begin
      quiet_inputs();
      test_reset();
      test_cfg_only();
      test_round_robin();
      test_seq_lock();
      test_refresh();
      test_max_seq();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ddr3_cmd_arbiter.md
Name: ddr3_cmd_arbiter

Overview:
- Shares the single DDL command port between three requesters:
  - the configuration/refresh sequencer (cfg), highest priority;
  - the main memory-controller FSM (port A);
  - the fast-read bypass controller (port B).
- Registered grant. Round-robin between A and B. Sequence-locking keeps multi-command transactions (ACT→RD/WR→PRE) atomic.
- Blocks new A/B grants while a refresh is pending or before initialisation completes.
- Sits between the controller FSMs and the DDL.

Parameters:
- DDR_ROW_BITS, 15, row/address width; RSB = DDR_ROW_BITS-1.
- CMD_NOP, 3'b111, command value driven when no grant is held.
- MAX_SEQ, 8, maximum consecutive accepted commands under one lock before a forced release; range 2..255.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_run_i  in  1  initialisation complete; while low only cfg is granted.
- ref_i  in  1  refresh pending, from the refresh timer.
- cfg_req_i / cfg_seq_i  in  1 each  cfg command request / keep-lock flag.
- cfg_cmd_i  in  3  cfg command.
- cfg_ba_i  in  3  cfg bank.
- cfg_adr_i  in  RSB+1  cfg address.
- cfg_rdy_o  out  1  cfg command accepted.
- a_req_i, a_seq_i, a_cmd_i, a_ba_i, a_adr_i  in  same widths as cfg  port A request bundle.
- a_rdy_o  out  1  port A command accepted.
- a_ref_o  out  1  copy of ref_i for port A.
- b_req_i, b_seq_i, b_cmd_i, b_ba_i, b_adr_i  in  same widths as cfg  port B request bundle.
- b_rdy_o  out  1  port B command accepted.
- b_ref_o  out  1  copy of ref_i for port B.
- ddl_req_o  out  1  command request to the DDL.
- ddl_seq_o  out  1  seq flag of the granted port.
- ddl_cmd_o  out  3  command of the granted port.
- ddl_ba_o  out  3  bank of the granted port.
- ddl_adr_o  out  RSB+1  address of the granted port.
- ddl_rdy_i  in  1  DDL accepts the command.
- lock_err_o  out  1  sticky flag: MAX_SEQ overrun.

Behaviour:
- States: IDLE, G_CFG, G_A, G_B. State, round-robin pointer (rr, 0 = A preferred), seq counter (8 bits) and lock_err_o are registers.
- Reset (asynchronous): state=IDLE, rr=0, count=0, lock_err_o=0.
- Outputs while in IDLE:
  - ddl_req_o=0, ddl_seq_o=0, ddl_cmd_o=CMD_NOP, ddl_ba_o=0, ddl_adr_o=0;
  - all *_rdy_o=0.
- Outputs while in G_x: ddl_* are a combinational mux of port x inputs; x_rdy_o = ddl_rdy_i & x_req_i; other rdy outputs 0.
- A command is accepted on a cycle with ddl_req_o & ddl_rdy_i.
- IDLE grant priority, evaluated each cycle, granted state entered on the next edge:
  1. cfg_req_i → G_CFG.
  2. else if cfg_run_i & ~ref_i: both A and B requesting → A if rr=0, else B. Only one requesting → that port.
  3. else stay in IDLE.
- Latency: a request in IDLE at cycle 0 → ddl_req_o=1 at cycle 1. A zero-wait accept completes at cycle 1.
- Leaving G_x:
  - Accept with seq=0 → IDLE next cycle; count=0. For A/B, rr points to the other port.
  - Accept with seq=1 → stay; count+1.
  - Accept with seq=1 and count = MAX_SEQ-1 → forced release to IDLE; lock_err_o set.
  - x_req_i low while granted (protocol violation) → IDLE next cycle, no accept.
- There is always one IDLE cycle between grants, including re-grant of the same port.
- ref_i only gates new A/B grants. A held lock (seq=1) completes before cfg gets the port.
- ref_i is also copied combinationally to a_ref_o and b_ref_o.
- Reset mid-lock → immediate IDLE; requesters must reissue.
- lock_err_o clears only on reset.

Test Plan:
1. cfg_run_i=0, a_req_i=1, cfg_req_i=1 with cmd=3'b010 at cycle 0 → cycle 1: ddl_req_o=1, ddl_cmd_o=3'b010. Port A is never granted while cfg_run_i=0.
2. cfg_run_i=1, a_req_i and b_req_i held, all seq=0, ddl_rdy_i=1 → grants alternate A, IDLE, B, IDLE, A. Exactly one rdy pulse per grant.
3. Port A issues ACT(seq=1), RD(seq=1), PRE(seq=0) while b_req_i=1 → three consecutive A commands with no IDLE between them, then IDLE, then a B grant.
4. ref_i=1 during an A lock with b_req_i=1 → the A lock completes; B is not granted until ref_i=0. cfg_req_i=1 → G_CFG. a_ref_o and b_ref_o track ref_i.
5. Port A holds seq=1 for 8 commands (MAX_SEQ=8) → forced IDLE after the 8th accept; lock_err_o=1 until reset.
6. Assert reset asynchronously while in G_B with ddl_rdy_i=0 → ddl_req_o=0, ddl_cmd_o=3'b111 and b_rdy_o=0 immediately, without waiting for a clock edge.
